// File: rtl/spi_host_shift_register_param.sv
// SPI host data path: a DataWidth-bit shift register serialising TX words onto 1/2/4/8 lanes
// and deserialising RX lanes into words, followed by an RxDepth-entry RX FIFO.
module spi_host_shift_register_param #(
  parameter int DataWidth = 8,
  parameter int NumLanes  = 4,
  parameter int RxDepth   = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         sw_rst_i,
  input  logic [1:0]                   speed_i,
  input  logic                         lsb_first_i,
  input  logic                         wr_en_i,
  output logic                         wr_ready_o,
  input  logic                         rd_en_i,
  output logic                         rd_ready_o,
  input  logic                         shift_en_i,
  input  logic                         sample_en_i,
  input  logic                         full_cyc_i,
  input  logic                         last_read_i,
  input  logic                         last_write_i,
  input  logic [DataWidth-1:0]         tx_data_i,
  input  logic                         tx_valid_i,
  output logic                         tx_ready_o,
  output logic                         tx_flush_o,
  output logic [DataWidth-1:0]         rx_data_o,
  output logic                         rx_valid_o,
  input  logic                         rx_ready_i,
  output logic                         rx_last_o,
  output logic [$clog2(RxDepth+1)-1:0] rx_level_o,
  input  logic [NumLanes-1:0]          sd_i,
  output logic [NumLanes-1:0]          sd_o
);

  localparam int LvlW    = $clog2(RxDepth + 1);
  localparam int PtrW    = (RxDepth > 1) ? $clog2(RxDepth) : 1;
  localparam int MisoIdx = (NumLanes > 1) ? 1 : 0;

  logic [DataWidth-1:0] sr_q, sr_d, sr_shifted;
  logic [NumLanes-1:0]  sd_i_q, sd_i_d, next_bits;
  logic [3:0]           lanes;
  logic                 legal;
  logic [7:0]           nb8, mask8;
  logic [DataWidth-1:0] in_dw, mask_dw, out_dw;

  assign wr_ready_o = tx_valid_i;
  assign tx_ready_o = wr_en_i;
  assign tx_flush_o = last_write_i;

  always_comb begin
    case (speed_i)
      2'd0:    lanes = 4'd1;
      2'd1:    lanes = 4'd2;
      2'd2:    lanes = 4'd4;
      default: lanes = 4'd8;
    endcase
    legal     = (int'(lanes) <= NumLanes);
    next_bits = full_cyc_i ? sd_i : sd_i_q;
    nb8       = 8'(next_bits);
    // Standard mode receives on MISO, which is lane 1.
    if (speed_i == 2'd0) nb8 = {7'd0, next_bits[MisoIdx]};
    mask8   = (8'd1 << lanes) - 8'd1;
    in_dw   = DataWidth'(nb8 & mask8);
    mask_dw = DataWidth'(mask8);
    if (lsb_first_i) begin
      sr_shifted = (sr_q >> lanes) | (in_dw << (DataWidth - int'(lanes)));
      out_dw     = sr_q & mask_dw;
    end else begin
      sr_shifted = (sr_q << lanes) | in_dw;
      out_dw     = (sr_q >> (DataWidth - int'(lanes))) & mask_dw;
    end
    if (!legal) begin
      sr_shifted = '0;
      out_dw     = '0;
    end
  end

  assign sd_o = out_dw[NumLanes-1:0];

  always_comb begin
    sr_d = sr_q;
    if (sw_rst_i)                   sr_d = '0;
    else if (wr_en_i && tx_valid_i) sr_d = tx_data_i;
    else if (shift_en_i)            sr_d = sr_shifted;
  end

  always_comb begin
    sd_i_d = sd_i_q;
    if (sw_rst_i)         sd_i_d = '0;
    else if (sample_en_i) sd_i_d = sd_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q   <= '0;
      sd_i_q <= '0;
    end else begin
      sr_q   <= sr_d;
      sd_i_q <= sd_i_d;
    end
  end

  // RX FIFO: each entry is {last, data}; the pushed word includes the current beat.
  logic [DataWidth:0]  mem_q [RxDepth];
  logic [DataWidth:0]  head;
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [LvlW-1:0]     level_q;
  logic                push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RxDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign rx_valid_o = (level_q != '0);
  assign pop        = rx_valid_o & rx_ready_i;
  assign rd_ready_o = (level_q < LvlW'(RxDepth)) | pop;
  assign push       = rd_en_i & rd_ready_o;
  assign head       = mem_q[rptr_q];
  assign rx_data_o  = rx_valid_o ? head[DataWidth-1:0] : '0;
  assign rx_last_o  = rx_valid_o & head[DataWidth];
  assign rx_level_o = level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < RxDepth; i++) mem_q[i] <= '0;
    end else if (sw_rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < RxDepth; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= {last_read_i, sr_shifted};
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      if (push && !pop)      level_q <= level_q + LvlW'(1);
      else if (pop && !push) level_q <= level_q - LvlW'(1);
    end
  end

endmodule

// File: tb/tb_spi_host_shift_register_param.sv
// Directed bench: instance A (8-bit, 4 lanes, depth 2) and instance B (16-bit, 8 lanes, depth 3).
module tb_spi_host_shift_register_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A
  logic       a_sw_rst = 0, a_lsb = 0, a_wr_en = 0, a_rd_en = 0, a_shift = 0, a_sample = 0;
  logic       a_full = 0, a_lread = 0, a_lwrite = 0, a_tx_valid = 0, a_rx_ready = 0;
  logic [1:0] a_speed = 2'd2;
  logic [7:0] a_tx = 0;
  logic [3:0] a_sd_i = 0;
  logic       a_wr_ready, a_rd_ready, a_tx_ready, a_flush, a_rx_valid, a_rx_last;
  logic [7:0] a_rx_data;
  logic [1:0] a_level;
  logic [3:0] a_sd_o;

  // Instance B
  logic        b_sw_rst = 0, b_lsb = 0, b_wr_en = 0, b_rd_en = 0, b_shift = 0, b_sample = 0;
  logic        b_full = 0, b_lread = 0, b_lwrite = 0, b_tx_valid = 0, b_rx_ready = 0;
  logic [1:0]  b_speed = 2'd3;
  logic [15:0] b_tx = 0;
  logic [7:0]  b_sd_i = 0;
  logic        b_wr_ready, b_rd_ready, b_tx_ready, b_flush, b_rx_valid, b_rx_last;
  logic [15:0] b_rx_data;
  logic [1:0]  b_level;
  logic [7:0]  b_sd_o;

  spi_host_shift_register_param #(.DataWidth(8), .NumLanes(4), .RxDepth(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .sw_rst_i(a_sw_rst), .speed_i(a_speed), .lsb_first_i(a_lsb),
    .wr_en_i(a_wr_en), .wr_ready_o(a_wr_ready), .rd_en_i(a_rd_en), .rd_ready_o(a_rd_ready),
    .shift_en_i(a_shift), .sample_en_i(a_sample), .full_cyc_i(a_full), .last_read_i(a_lread),
    .last_write_i(a_lwrite), .tx_data_i(a_tx), .tx_valid_i(a_tx_valid), .tx_ready_o(a_tx_ready),
    .tx_flush_o(a_flush), .rx_data_o(a_rx_data), .rx_valid_o(a_rx_valid), .rx_ready_i(a_rx_ready),
    .rx_last_o(a_rx_last), .rx_level_o(a_level), .sd_i(a_sd_i), .sd_o(a_sd_o)
  );

  spi_host_shift_register_param #(.DataWidth(16), .NumLanes(8), .RxDepth(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .sw_rst_i(b_sw_rst), .speed_i(b_speed), .lsb_first_i(b_lsb),
    .wr_en_i(b_wr_en), .wr_ready_o(b_wr_ready), .rd_en_i(b_rd_en), .rd_ready_o(b_rd_ready),
    .shift_en_i(b_shift), .sample_en_i(b_sample), .full_cyc_i(b_full), .last_read_i(b_lread),
    .last_write_i(b_lwrite), .tx_data_i(b_tx), .tx_valid_i(b_tx_valid), .tx_ready_o(b_tx_ready),
    .tx_flush_o(b_flush), .rx_data_o(b_rx_data), .rx_valid_o(b_rx_valid), .rx_ready_i(b_rx_ready),
    .rx_last_o(b_rx_last), .rx_level_o(b_level), .sd_i(b_sd_i), .sd_o(b_sd_o)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_wr_en = 0; a_tx_valid = 0; a_shift = 0; a_rd_en = 0; a_sample = 0;
    a_lread = 0; a_rx_ready = 0; a_sw_rst = 0;
  endtask

  task automatic a_pop();
    a_idle();
    a_rx_ready = 1;
    cyc();
    a_rx_ready = 0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (a_sd_o !== 4'h0) begin n_err++; $display("FAIL reset_sd_o got=%h want=0", a_sd_o); end
    n_cmp++; if (a_rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid got=%b want=0", a_rx_valid); end
    n_cmp++; if (a_level !== 2'd0) begin n_err++; $display("FAIL reset_level got=%0d want=0", a_level); end
    n_cmp++; if (a_rd_ready !== 1'b1) begin n_err++; $display("FAIL reset_rd_ready got=%b want=1", a_rd_ready); end
    n_cmp++; if ({a_rx_last, a_rx_data} !== 9'h0) begin n_err++; $display("FAIL reset_rx_head got=%h want=0", {a_rx_last, a_rx_data}); end
    n_cmp++; if (b_sd_o !== 8'h0) begin n_err++; $display("FAIL reset_b_sd_o got=%h want=0", b_sd_o); end
  endtask

  task automatic test_octal();
    b_speed = 2'd3; b_lsb = 0; b_full = 1;
    b_wr_en = 1; b_tx_valid = 1; b_tx = 16'hA55A; b_lwrite = 1;
    #1;
    n_cmp++; if ({b_tx_ready, b_wr_ready, b_flush} !== 3'b111) begin n_err++; $display("FAIL octal_passthru got=%b want=111", {b_tx_ready, b_wr_ready, b_flush}); end
    cyc();
    b_wr_en = 0; b_tx_valid = 0; b_lwrite = 0;
    #1;
    n_cmp++; if (b_sd_o !== 8'hA5) begin n_err++; $display("FAIL octal_beat0 got=%h want=a5", b_sd_o); end
    b_shift = 1; b_sd_i = 8'h3C;
    cyc();
    n_cmp++; if (b_sd_o !== 8'h5A) begin n_err++; $display("FAIL octal_beat1 got=%h want=5a", b_sd_o); end
    b_sd_i = 8'hC3; b_rd_en = 1; b_lread = 1;
    cyc();
    b_shift = 0; b_rd_en = 0; b_lread = 0;
    n_cmp++; if ({b_rx_valid, b_rx_last, b_rx_data} !== {2'b11, 16'h3CC3}) begin n_err++; $display("FAIL octal_rx got=%b%b_%h want=11_3cc3", b_rx_valid, b_rx_last, b_rx_data); end
    n_cmp++; if (b_level !== 2'd1) begin n_err++; $display("FAIL octal_level got=%0d want=1", b_level); end
    b_rx_ready = 1;
    cyc();
    b_rx_ready = 0;
    n_cmp++; if (b_level !== 2'd0) begin n_err++; $display("FAIL octal_pop_level got=%0d want=0", b_level); end
  endtask

  task automatic test_std_lsb();
    logic exp_bit;
    a_idle();
    a_speed = 2'd0; a_lsb = 1; a_full = 1;
    a_wr_en = 1; a_tx_valid = 1; a_tx = 8'h01;
    cyc();
    a_wr_en = 0; a_tx_valid = 0;
    for (int i = 0; i < 8; i++) begin
      a_shift = 1;
      a_sd_i = (i == 0) ? 4'b0010 : 4'b1101;
      a_rd_en = (i == 7);
      exp_bit = (i == 0);
      #1;
      n_cmp++; if (a_sd_o !== {3'b000, exp_bit}) begin n_err++; $display("FAIL std_sd_o beat=%0d got=%b want=%b", i, a_sd_o, {3'b000, exp_bit}); end
      cyc();
    end
    a_idle();
    n_cmp++; if ({a_rx_valid, a_rx_data} !== 9'h101) begin n_err++; $display("FAIL std_rx got=%b_%h want=1_01", a_rx_valid, a_rx_data); end
    a_pop();
    a_lsb = 0;
  endtask

  task automatic test_quad_sampled();
    a_idle();
    a_speed = 2'd2; a_full = 0;
    a_wr_en = 1; a_tx_valid = 1; a_tx = 8'h12;
    a_sample = 1; a_sd_i = 4'hB;
    cyc();
    a_idle();
    n_cmp++; if (a_sd_o !== 4'h1) begin n_err++; $display("FAIL quad_sd_o got=%h want=1", a_sd_o); end
    a_sd_i = 4'h0; a_shift = 1; a_rd_en = 1;
    cyc();
    a_idle();
    n_cmp++; if (a_rx_data !== 8'h2B) begin n_err++; $display("FAIL quad_sampled got=%h want=2b", a_rx_data); end
    a_pop();
  endtask

  task automatic test_illegal();
    a_idle();
    a_speed = 2'd3; a_full = 1;
    a_wr_en = 1; a_tx_valid = 1; a_tx = 8'hFF;
    cyc();
    a_idle();
    n_cmp++; if (a_sd_o !== 4'h0) begin n_err++; $display("FAIL illegal_sd_o got=%h want=0", a_sd_o); end
    a_sd_i = 4'hF; a_shift = 1; a_rd_en = 1;
    cyc();
    a_idle();
    n_cmp++; if ({a_rx_valid, a_rx_data} !== 9'h100) begin n_err++; $display("FAIL illegal_rx got=%b_%h want=1_00", a_rx_valid, a_rx_data); end
    a_pop();
    a_speed = 2'd2;
    a_wr_en = 1; a_tx_valid = 1; a_tx = 8'hC5;
    cyc();
    a_idle();
    n_cmp++; if (a_sd_o !== 4'hC) begin n_err++; $display("FAIL recover_sd_o got=%h want=c", a_sd_o); end
    a_sd_i = 4'hA; a_shift = 1; a_rd_en = 1;
    cyc();
    a_idle();
    n_cmp++; if (a_rx_data !== 8'h5A) begin n_err++; $display("FAIL recover_rx got=%h want=5a", a_rx_data); end
    a_pop();
  endtask

  task automatic test_fifo_full();
    a_idle();
    a_speed = 2'd2; a_full = 1;
    a_wr_en = 1; a_tx_valid = 1; a_tx = 8'h00;
    cyc();
    a_idle();
    a_shift = 1; a_rd_en = 1; a_sd_i = 4'h1;
    cyc();
    n_cmp++; if ({a_level, a_rd_ready} !== 3'b011) begin n_err++; $display("FAIL fifo_push1 lvl/rdy got=%b want=011", {a_level, a_rd_ready}); end
    a_sd_i = 4'h2;
    cyc();
    n_cmp++; if ({a_level, a_rd_ready} !== 3'b100) begin n_err++; $display("FAIL fifo_full lvl/rdy got=%b want=100", {a_level, a_rd_ready}); end
    a_sd_i = 4'h3;
    cyc();
    n_cmp++; if ({a_level, a_rx_data} !== {2'd2, 8'h01}) begin n_err++; $display("FAIL fifo_drop lvl=%0d head=%h want 2/01", a_level, a_rx_data); end
    a_sd_i = 4'h4; a_rx_ready = 1;
    #1;
    n_cmp++; if (a_rd_ready !== 1'b1) begin n_err++; $display("FAIL fifo_rdy_on_pop got=%b want=1", a_rd_ready); end
    cyc();
    n_cmp++; if ({a_level, a_rx_data} !== {2'd2, 8'h12}) begin n_err++; $display("FAIL fifo_pushpop lvl=%0d head=%h want 2/12", a_level, a_rx_data); end
    a_shift = 0; a_rd_en = 0;
    cyc();
    n_cmp++; if ({a_level, a_rx_data} !== {2'd1, 8'h34}) begin n_err++; $display("FAIL fifo_order lvl=%0d head=%h want 1/34", a_level, a_rx_data); end
    cyc();
    n_cmp++; if ({a_level, a_rx_valid} !== 3'b000) begin n_err++; $display("FAIL fifo_empty got=%b want=000", {a_level, a_rx_valid}); end
    a_idle();
  endtask

  task automatic test_sw_rst();
    a_idle();
    a_speed = 2'd2; a_full = 1;
    a_wr_en = 1; a_tx_valid = 1; a_tx = 8'h96;
    cyc();
    a_idle();
    a_shift = 1; a_rd_en = 1; a_sd_i = 4'h7;
    cyc();
    n_cmp++; if ({a_level, a_rx_data} !== {2'd1, 8'h67}) begin n_err++; $display("FAIL swrst_pre lvl=%0d head=%h want 1/67", a_level, a_rx_data); end
    a_sw_rst = 1; a_sd_i = 4'h5; a_sample = 1; a_wr_en = 1; a_tx_valid = 1;
    cyc();
    a_idle();
    n_cmp++; if ({a_level, a_rx_valid, a_rd_ready} !== 4'b0001) begin n_err++; $display("FAIL swrst_fifo got=%b want=0001", {a_level, a_rx_valid, a_rd_ready}); end
    n_cmp++; if ({a_sd_o, a_rx_data} !== 12'h000) begin n_err++; $display("FAIL swrst_data got=%h want=000", {a_sd_o, a_rx_data}); end
    a_full = 0; a_sd_i = 4'hF; a_shift = 1; a_rd_en = 1;
    cyc();
    a_idle();
    n_cmp++; if ({a_rx_valid, a_rx_data} !== 9'h100) begin n_err++; $display("FAIL swrst_sample_clr got=%b_%h want=1_00", a_rx_valid, a_rx_data); end
    a_pop();
    a_full = 1;
  endtask

  task automatic test_async_rst();
    a_idle();
    a_speed = 2'd2; a_full = 1;
    a_wr_en = 1; a_tx_valid = 1; a_tx = 8'h0F;
    cyc();
    a_idle();
    a_shift = 1; a_rd_en = 1; a_sd_i = 4'hA;
    cyc();
    a_rd_en = 0;
    n_cmp++; if ({a_sd_o, a_level} !== {4'hF, 2'd1}) begin n_err++; $display("FAIL arst_pre sd_o=%h lvl=%0d want f/1", a_sd_o, a_level); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({a_sd_o, a_level, a_rx_valid, a_rd_ready} !== 8'h01) begin n_err++; $display("FAIL arst_now got=%h want=01", {a_sd_o, a_level, a_rx_valid, a_rd_ready}); end
    a_idle();
    #2 rst_n = 1;
    cyc();
    n_cmp++; if (a_sd_o !== 4'h0) begin n_err++; $display("FAIL arst_after sd_o=%h want=0", a_sd_o); end
  endtask

  initial begin
    #12 rst_n = 1;
    test_reset();
    cyc();
    test_octal();
    test_std_lsb();
    test_quad_sampled();
    test_illegal();
    test_fifo_full();
    test_sw_rst();
    test_async_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_host_shift_register_param.md
Name: spi_host_shift_register_param

Overview:
Parametrised next-generation SPI host data path: a DataWidth-bit shift register serialising TX words onto 1/2/4/8 lanes and deserialising RX lanes into words. Sits between the SPI host FSM (shift/sample/word strobes) and the byte-merge/byte-select stages.
Adds four things over the fixed 8-bit, 4-lane shift register: configurable word width, octal mode, LSB-first ordering, and an RxDepth-entry RX FIFO with occupancy output.

Parameters:
DataWidth, 8, shift register/word width; a multiple of NumLanes, at least 8
NumLanes, 4, physical data lanes (1, 2, 4 or 8)
RxDepth, 2, RX FIFO entries (at least 1); each entry holds {last, data}

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
sw_rst_i  in  1  synchronous clear of all state
speed_i  in  2  0 Standard, 1 Dual, 2 Quad, 3 Octal
lsb_first_i  in  1  1 = shift LSB first
wr_en_i  in  1  FSM requests a TX word load
wr_ready_o  out  1  TX word available (= tx_valid_i)
rd_en_i  in  1  FSM pushes the assembled RX word
rd_ready_o  out  1  RX FIFO can accept a push
shift_en_i  in  1  advance shift register one beat
sample_en_i  in  1  capture sd_i into the sample register
full_cyc_i  in  1  use live sd_i instead of the sampled copy
last_read_i  in  1  tag the pushed RX word as last
last_write_i  in  1  flush request passed to TX source
tx_data_i  in  DataWidth  TX word
tx_valid_i  in  1  TX word valid
tx_ready_o  out  1  = wr_en_i
tx_flush_o  out  1  = last_write_i
rx_data_o  out  DataWidth  FIFO head data
rx_valid_o  out  1  FIFO non-empty
rx_ready_i  in  1  downstream accepts head
rx_last_o  out  1  FIFO head last tag
rx_level_o  out  $clog2(RxDepth+1)  FIFO occupancy
sd_i  in  NumLanes  lane inputs
sd_o  out  NumLanes  lane outputs

Behaviour:
- Lanes per beat k: Standard=1, Dual=2, Quad=4, Octal=8.
- A mode is illegal if k > NumLanes. In an illegal mode sr_shifted=0 and sd_o=0; no lockup; the next legal beat recovers.
- Input bits: next_bits = full_cyc_i ? sd_i : sd_i_q. Standard samples sd_i[1] (MISO); all other modes use next_bits[k-1:0].
- MSB-first (lsb_first_i=0): sr_shifted = {sr_q[DataWidth-1-k:0], next_bits[k-1:0]}. sd_o[k-1:0] = sr_q[DataWidth-1 -: k].
- LSB-first: sr_shifted = {next_bits[k-1:0], sr_q[DataWidth-1:k]}. sd_o[k-1:0] = sr_q[k-1:0].
- Standard drives sd_o[0] only. All unused sd_o bits are 0.
- sr_d priority: sw_rst_i -> 0; else wr_en_i & tx_valid_i -> tx_data_i; else shift_en_i -> sr_shifted; else hold. Load beats shift in the same cycle.
- sd_i_q: sw_rst_i -> 0; else sample_en_i -> sd_i; else hold.
- speed_i and lsb_first_i are evaluated every cycle, not latched per word. Changing them mid-word corrupts only that word.
- RX FIFO:
  - Push when rd_en_i & rd_ready_o; the pushed entry is {last_read_i, sr_shifted}, so the final beat is included.
  - Pop when rx_valid_o & rx_ready_i.
  - rd_ready_o = (level < RxDepth) | pop.
  - Simultaneous push and pop: allowed at any level; level unchanged; order preserved.
  - Push attempted while full with no pop: dropped and not stored.
  - Head outputs are stable while rx_valid_o=1 and no pop.
  - Pointers wrap modulo RxDepth; RxDepth need not be a power of 2.
  - rx_level_o updates one cycle after push/pop.
- Reset values (rst_ni low, or sw_rst_i at the next edge): sr_q=0, sd_i_q=0, FIFO empty, level=0, rx_valid_o=0, rx_data_o=0, rx_last_o=0, sd_o=0, rd_ready_o=1. sw_rst_i overrides simultaneous push/load/shift.
- Latency: word load to first sd_o bit is 1 cycle. Final beat to rx_valid_o is 1 cycle (push in the final-beat cycle).

Test Plan:
- DataWidth=16, NumLanes=8, Octal, MSB-first: load 16'hA55A, 2 shifts with sd_i=8'h3C then 8'hC3 -> sd_o 8'hA5 then 8'h5A; pushed word 16'h3CC3.
- Standard, LSB-first, DataWidth=8: load 8'h01 -> sd_o[0]=1 then 0 x7. 8 shifts with sd_i[1] pattern 1,0,0,0,0,0,0,0 plus push -> rx_data_o=8'h01.
- Quad, full_cyc_i=0: sample_en_i with sd_i=4'hB, then sd_i=4'h0 at shift -> shifted nibble is 4'hB (sampled copy, not live input).
- RxDepth=2, rx_ready_i=0: three pushes -> rd_ready_o=0 after the second, level=2, third push dropped. Then a simultaneous push+pop at full -> level stays 2, head = second word.
- Octal selected with NumLanes=4 -> sd_o=0, pushed word 0. Then switch to Quad -> normal operation.
- sw_rst_i mid-word with FIFO level 1 and the same-cycle push -> next cycle sr_q=0, level=0, rx_valid_o=0. Also assert rst_ni asynchronously mid-shift -> outputs zero immediately.
